// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the load/store memory controller:
// size encodings, FSM states, bus payload structs and the alignment check.
package ysyx_25020047_pkg;

    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned MASK_W      = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request context needed to extract load data once memory answers
    typedef struct packed {
        logic [1:0] off;
        size_e      size;
        logic       sext;
    } ctx_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [MASK_W-1:0] wmask;
    } mem_pl_t;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] rdata;
    } rsp_pl_t;

    // Illegal size or an address not aligned to the access size
    function automatic logic is_bad_access(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25020047_memctl_if.sv
// Request/response and memory-side signal bundle of the memory controller.
// slave = the controller, master = the CPU/memory environment around it.
interface ysyx_25020047_memctl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
        input  rsp_ready, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
        output rsp_ready, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ysyx_25020047_memctl_lane.sv
// Byte-lane steering: packs store data/mask into word lanes and extracts
// plus zero/sign-extends load data from a word. Purely combinational.
module ysyx_25020047_LANE
    import ysyx_25020047_pkg::*;
(
    input  logic [1:0]        off_i,
    input  size_e             size_i,
    input  logic              sext_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [MASK_W-1:0] wmask_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] rsh;

    assign shamt = {off_i, 3'b000};

    always_comb begin
        wdata_o = wdata_i << shamt;
        rsh     = rdata_i >> shamt;
        wmask_o = '0;
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: begin
                wmask_o = 4'b0001 << off_i;
                rdata_o = {{24{sext_i & rsh[7]}}, rsh[7:0]};
            end
            SZ_HALF: begin
                wmask_o = 4'b0011 << off_i;
                rdata_o = {{16{sext_i & rsh[15]}}, rsh[15:0]};
            end
            SZ_WORD: begin
                wmask_o = 4'b1111;
                rdata_o = rsh;
            end
            default: begin
                wmask_o = '0;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_memctl.sv
// Single-outstanding load/store controller: accepts a CPU request, issues a
// word-aligned memory access with lane masking, and returns extended data.
module ysyx_25020047_memctl
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_25020047_memctl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctx_t             ctx_q, ctx_d;
    mem_pl_t          memp_q, memp_d;
    rsp_pl_t          rsp_q, rsp_d;
    logic             req_ready_q, rsp_valid_q, mem_req_q;

    logic              sel_req;
    logic [1:0]        lane_off;
    size_e             lane_size;
    logic              lane_sext;
    logic [MASK_W-1:0] lane_wmask;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_rdata;

    // One lane unit: fed by the live request while idle, by the latched context in MEM
    assign sel_req   = (state_q == ST_IDLE);
    assign lane_off  = sel_req ? bus.req_addr[1:0] : ctx_q.off;
    assign lane_size = sel_req ? size_e'(bus.req_size) : ctx_q.size;
    assign lane_sext = sel_req ? bus.req_sext : ctx_q.sext;

    ysyx_25020047_LANE u_lane (
        .off_i   (lane_off),
        .size_i  (lane_size),
        .sext_i  (lane_sext),
        .wdata_i (bus.req_wdata),
        .rdata_i (bus.mem_rdata),
        .wmask_o (lane_wmask),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        memp_d  = memp_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    ctx_d.off  = bus.req_addr[1:0];
                    ctx_d.size = size_e'(bus.req_size);
                    ctx_d.sext = bus.req_sext;
                    if (is_bad_access(size_e'(bus.req_size), bus.req_addr[1:0])) begin
                        rsp_d.err   = 1'b1;
                        rsp_d.rdata = '0;
                        state_d     = ST_RESP;
                    end else begin
                        memp_d.we    = bus.req_wen;
                        memp_d.addr  = {bus.req_addr[31:2], 2'b00};
                        memp_d.wdata = lane_wdata;
                        memp_d.wmask = lane_wmask;
                        cnt_d        = '0;
                        state_d      = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    rsp_d.err   = 1'b0;
                    rsp_d.rdata = memp_q.we ? '0 : lane_rdata;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they track state_q exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctx_q       <= '0;
            memp_q      <= '0;
            rsp_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctx_q       <= ctx_d;
            memp_q      <= memp_d;
            rsp_q       <= rsp_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            mem_req_q   <= (state_d == ST_MEM);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = memp_q.we;
    assign bus.mem_addr  = memp_q.addr;
    assign bus.mem_wdata = memp_q.wdata;
    assign bus.mem_wmask = memp_q.wmask;

endmodule

// File: tb/tb_ysyx_25020047_memctl.sv
// Directed bench for the memory controller: expected responses are queued at
// request time and compared when the controller presents rsp_valid.
module tb_ysyx_25020047_memctl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    ysyx_25020047_memctl_if bus ();

    ysyx_25020047_memctl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({pfx, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({pfx, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
        check({pfx, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check({pfx, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({pfx, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
        check({pfx, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({pfx, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    endtask

    // Present one request for a single accept cycle; ends one cycle after the accept edge
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sext);
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_valid = 1'b1;
        check("accept_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        exp_t e;
        int   n = 0;
        while (!bus.rsp_valid && n < 40) begin
            step();
            n++;
        end
        check("rsp_arrives", 32'(bus.rsp_valid), 32'd1);
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_xfer(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sext, input logic [31:0] mrd,
                           input logic [3:0] ewm, input logic [31:0] ewd, input logic [31:0] erd);
        exp_t e;
        e.rdata = erd;
        e.err   = 1'b0;
        sb.push_back(e);
        issue(wen, addr, wdata, size, sext);
        check("mem_req", 32'(bus.mem_req), 32'd1);
        check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("mem_we", 32'(bus.mem_we), 32'(wen));
        check("mem_wmask", 32'(bus.mem_wmask), 32'(ewm));
        if (wen) check("mem_wdata", bus.mem_wdata, ewd);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mrd;
        step();
        bus.mem_ack = 1'b0;
        check("latency_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("mem_req_after_ack", 32'(bus.mem_req), 32'd0);
        wait_rsp();
    endtask

    task automatic bad_req(input logic [31:0] addr, input logic [1:0] size);
        exp_t e;
        e.rdata = 32'd0;
        e.err   = 1'b1;
        sb.push_back(e);
        issue(1'b0, addr, 32'hFFFF_FFFF, size, 1'b1);
        check("bad_no_mem_req", 32'(bus.mem_req), 32'd0);
        check("bad_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        wait_rsp();
        check("bad_no_mem_req_after", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   n;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_size  = 2'd0;
        bus.req_sext  = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Loads: sign/zero extension across lanes, first-cycle ack
        do_xfer(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b1, 32'h8544_3322, 4'b1000, 32'd0, 32'hFFFF_FF85);
        do_xfer(1'b0, 32'h8000_0002, 32'd0, 2'd1, 1'b0, 32'h8544_3322, 4'b1100, 32'd0, 32'h0000_8544);
        do_xfer(1'b0, 32'h8000_0002, 32'd0, 2'd1, 1'b1, 32'h8544_3322, 4'b1100, 32'd0, 32'hFFFF_8544);
        do_xfer(1'b0, 32'h8000_0001, 32'd0, 2'd0, 1'b1, 32'h8544_3322, 4'b0010, 32'd0, 32'h0000_0033);
        do_xfer(1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b1, 32'h8544_3322, 4'b1111, 32'd0, 32'h8544_3322);

        // Stores: lane packing, response data forced to zero
        do_xfer(1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0, 32'hDEAD_BEEF, 4'b0010, 32'h0000_AB00, 32'd0);
        do_xfer(1'b1, 32'h8000_0008, 32'h1234_5678, 2'd2, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h1234_5678, 32'd0);

        // Store half with delayed ack: mem_req must hold until ack
        e.rdata = 32'd0;
        e.err   = 1'b0;
        sb.push_back(e);
        issue(1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0);
        check("sh_mem_wmask", 32'(bus.mem_wmask), 32'h0000_000C);
        check("sh_mem_wdata", bus.mem_wdata, 32'hBEEF_0000);
        check("sh_mem_addr", bus.mem_addr, 32'h8000_0000);
        step();
        step();
        check("sh_mem_req_held", 32'(bus.mem_req), 32'd1);
        check("sh_req_ready_mem", 32'(bus.req_ready), 32'd0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        wait_rsp();

        // Misaligned and illegal-size requests
        bad_req(32'h8000_0001, 2'd2);
        bad_req(32'h8000_0003, 2'd1);
        bad_req(32'h8000_0000, 2'd3);

        // Timeout: no ack, mem_req high for exactly TIMEOUT cycles
        e.rdata = 32'd0;
        e.err   = 1'b1;
        sb.push_back(e);
        issue(1'b0, 32'h8000_0010, 32'd0, 2'd2, 1'b0);
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            step();
        end
        check("to_mem_req_cycles", 32'(n), 32'd16);
        check("to_mem_req_low", 32'(bus.mem_req), 32'd0);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        step();
        bus.mem_ack = 1'b0;
        wait_rsp();

        // Response backpressure with a competing request held high
        e.rdata = 32'hFFFF_FFF0;
        e.err   = 1'b0;
        sb.push_back(e);
        issue(1'b0, 32'h8000_0020, 32'd0, 2'd0, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_00F0;
        step();
        bus.mem_ack   = 1'b0;
        bus.req_addr  = 32'h8000_0040;
        bus.req_size  = 2'd2;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'hFFFF_FFF0);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        wait_rsp();
        bus.req_valid = 1'b0;
        check("handoff_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        check("handoff_not_accepted", 32'(bus.mem_req), 32'd0);
        check("handoff_still_idle", 32'(bus.req_ready), 32'd1);

        // Asynchronous reset in MEM abandons the access
        issue(1'b1, 32'h8000_0030, 32'hA5A5_A5A5, 2'd2, 1'b0);
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst_mem");
        #1 rst = 1'b0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("post_rst_no_mem_req", 32'(bus.mem_req), 32'd0);
        end
        bus.mem_ack = 1'b0;

        // Asynchronous reset in RESP drops the pending response
        issue(1'b0, 32'h8000_0002, 32'd0, 2'd2, 1'b0);
        check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst_resp");
        #1 rst = 1'b0;
        step();
        check("post_rst_resp_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // A fresh request still works after the abandoned ones
        do_xfer(1'b0, 32'h8000_0000, 32'd0, 2'd1, 1'b1, 32'h0000_7FFF, 4'b0011, 32'd0, 32'h0000_7FFF);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
